// File: rtl/fp_mul_pipe.sv
// IEEE-754 multiplier: RNE rounding, denormals flushed to zero. 3-cycle latency, one result per cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready in the same cycle.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception
);

  localparam int PW  = 2 * (MAN_W + 1);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW2-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } cls_t;

  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    cls_t c;
    c.zero = (e == '0);
    c.inf  = (&e) && (f == '0);
    c.nan  = (&e) && (f != '0);
    c.snan = c.nan && !f[MAN_W-1];
    return c;
  endfunction

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // S1: unpacked operands with hidden bit and class
  logic             s1_vld;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;
  cls_t             s1_ca, s1_cb;

  // S2: raw product, biased exponent, special-case summary
  logic                  s2_vld;
  logic                  s2_sign;
  logic [PW-1:0]         s2_prod;
  logic signed [EW2-1:0] s2_exp;
  logic                  s2_nan, s2_exc, s2_inf, s2_zero;

  logic [PW-1:0]         prod_n;
  logic signed [EW2-1:0] exp_sum_n;
  logic                  inv_n;

  assign prod_n    = {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
  assign exp_sum_n = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;
  assign inv_n     = (s1_ca.inf && s1_cb.zero) || (s1_cb.inf && s1_ca.zero);

  // S3: normalize, round, special cases, pack
  logic [PW-1:0]         norm;
  logic [MAN_W-1:0]      mant, frac;
  logic                  guard, sticky, inc, carry;
  logic signed [EW2-1:0] exp_n, exp_r;
  logic [DATA_W-1:0]     res_n;
  logic                  ovf_n, unf_n, exc_n;

  always_comb begin
    norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    mant   = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    inc    = guard && (sticky || mant[0]);
    {carry, frac} = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    exp_n  = s2_exp + {{(EW2-1){1'b0}}, s2_prod[PW-1]};
    exp_r  = exp_n + {{(EW2-1){1'b0}}, carry};

    res_n = {s2_sign, exp_r[EXP_W-1:0], frac};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    exc_n = 1'b0;
    if (s2_nan) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      exc_n = s2_exc;
    end else if (s2_inf) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      res_n = {s2_sign, {(DATA_W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      res_n = {s2_sign, {(DATA_W-1){1'b0}}};
      unf_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (!stall) begin
      s1_vld  <= in_valid;
      s1_sign <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
      s1_ea   <= op_a[DATA_W-2 -: EXP_W];
      s1_eb   <= op_b[DATA_W-2 -: EXP_W];
      s1_ma   <= {1'b1, op_a[MAN_W-1:0]};
      s1_mb   <= {1'b1, op_b[MAN_W-1:0]};
      s1_ca   <= classify(op_a[DATA_W-2 -: EXP_W], op_a[MAN_W-1:0]);
      s1_cb   <= classify(op_b[DATA_W-2 -: EXP_W], op_b[MAN_W-1:0]);

      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_prod <= prod_n;
      s2_exp  <= exp_sum_n;
      s2_nan  <= s1_ca.nan || s1_cb.nan || inv_n;
      s2_exc  <= inv_n || s1_ca.snan || s1_cb.snan;
      s2_inf  <= s1_ca.inf || s1_cb.inf;
      s2_zero <= s1_ca.zero || s1_cb.zero;

      // flags only ever accompany a real result
      out_valid <= s2_vld;
      res       <= res_n;
      overflow  <= s2_vld && ovf_n;
      underflow <= s2_vld && unf_n;
      exception <= s2_vld && exc_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: table of hand-computed products plus backpressure and reset sequences.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        overflow, underflow, exception;

  int total = 0;
  int bad   = 0;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  fl;  // {overflow, underflow, exception}
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic [2:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'b0, overflow, underflow, exception};
  endfunction

  // Caller is positioned just after a negedge; returns at the negedge where the result shows.
  task automatic run_vec(input int idx, input vec_t v);
    int k;
    in_valid = 1'b1;
    op_a = v.a;
    op_b = v.b;
    #1;
    chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_latency", idx), k, 32'd3);
    chk($sformatf("v%0d_res", idx), res, v.r);
    chk($sformatf("v%0d_flags", idx), flags(), {29'b0, v.fl});
  endtask

  logic [31:0] bp_a [6];
  logic [31:0] bp_e [6];

  initial begin
    vecs[0]  = mk(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    vecs[1]  = mk(32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000);
    vecs[2]  = mk(32'h3F800800, 32'h3F801800, 32'h3F802002, 3'b000);
    vecs[3]  = mk(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
    vecs[4]  = mk(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
    vecs[5]  = mk(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    vecs[6]  = mk(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    vecs[7]  = mk(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    vecs[8]  = mk(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000);
    vecs[9]  = mk(32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 3'b100);
    vecs[10] = mk(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
    vecs[11] = mk(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000);
    vecs[12] = mk(32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b001);
    vecs[13] = mk(32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);
    vecs[14] = mk(32'h7F800000, 32'h7F800000, 32'h7F800000, 3'b000);
    vecs[15] = mk(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    vecs[16] = mk(32'h00400000, 32'hC0000000, 32'h80000000, 3'b000);
    vecs[17] = mk(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000);
    vecs[18] = mk(32'h7F800000, 32'h80000000, 32'h7FC00000, 3'b001);
    vecs[19] = mk(32'hFFC00000, 32'h7F800000, 32'h7FC00000, 3'b000);

    // x * 2.0 only bumps the exponent field
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 32'h3F800000 | ((i + 1) << 20);
      bp_e[i] = bp_a[i] + 32'h00800000;
    end

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_flags", flags(), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // backpressure: 6 back-to-back ops, consumer stalls for cycles 4..7
    begin
      int issued = 0;
      int got = 0;
      int cyc = 0;
      logic prev_stall = 1'b0;
      logic [31:0] prev_res = '0;
      while (got < 6 && cyc < 60) begin
        @(negedge clk);
        out_ready = !(cyc >= 4 && cyc < 8);
        in_valid  = (issued < 6);
        op_a      = (issued < 6) ? bp_a[issued] : 32'h0;
        op_b      = 32'h40000000;
        #1;
        if (prev_stall) begin
          chk($sformatf("bp_hold_res_c%0d", cyc), res, prev_res);
          chk($sformatf("bp_hold_vld_c%0d", cyc), {31'b0, out_valid}, 32'd1);
        end
        if (cyc == 4) chk("bp_in_ready_drop", {31'b0, in_ready}, 32'd0);
        if (cyc == 8) chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        if (out_valid && out_ready) begin
          chk($sformatf("bp_res%0d", got), res, bp_e[got]);
          got++;
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = res;
        if (in_valid && in_ready) issued++;
        cyc++;
      end
      chk("bp_count", got, 32'd6);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk($sformatf("bp_no_dup%0d", i), {31'b0, out_valid}, 32'd0);
      end
    end

    // reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op_a = vecs[15 + i].a;
      op_b = vecs[15 + i].b;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_res", res, 32'd0);
    chk("mid_rst_flags", flags(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_flushed%0d", i), {31'b0, out_valid}, 32'd0);
    end
    run_vec(100, vecs[0]);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
